// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL / system reset domain.
// The master side is the supervisor; the slave side is the PLL primitive plus the reset consumers.
interface pll_lock_supervisor_if;
    logic       pll_lock;
    logic       restart;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       sys_rst_n;
    logic       locked;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    modport master (
        input  pll_lock, restart,
        output pll_resetb, pll_bypass, sys_rst_n, locked, fail, retry_cnt, state
    );

    modport slave (
        output pll_lock, restart,
        input  pll_resetb, pll_bypass, sys_rst_n, locked, fail, retry_cnt, state
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer running on the reference clock; releases sys_rst_n after a stable lock.
// Optional macro PLL_BYPASS_FALLBACK_EN: on FAIL, bypass the PLL and release the system on the reference clock.
module pll_lock_supervisor #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                    clk,
    input  logic                    resetb,
    pll_lock_supervisor_if.master   bus
);

    localparam int MAX_AB    = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_COUNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT);

`ifdef PLL_BYPASS_FALLBACK_EN
    localparam bit FALLBACK = 1'b1;
`else
    localparam bit FALLBACK = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]         retry_reg, retry_next;
    logic               lock_meta_reg, lock_s_reg;
    logic               pll_resetb_reg, pll_resetb_next;
    logic               pll_bypass_reg, pll_bypass_next;
    logic               sys_rst_n_reg, sys_rst_n_next;
    logic               locked_reg, locked_next;
    logic               fail_reg, fail_next;
    logic               do_retry;

    // LOCK is asynchronous to the reference clock
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= bus.pll_lock;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_reg      <= ST_HOLD;
            cnt_reg        <= '0;
            retry_reg      <= '0;
            pll_resetb_reg <= 1'b0;
            pll_bypass_reg <= 1'b0;
            sys_rst_n_reg  <= 1'b0;
            locked_reg     <= 1'b0;
            fail_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            retry_reg      <= retry_next;
            pll_resetb_reg <= pll_resetb_next;
            pll_bypass_reg <= pll_bypass_next;
            sys_rst_n_reg  <= sys_rst_n_next;
            locked_reg     <= locked_next;
            fail_reg       <= fail_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        do_retry   = 1'b0;

        if (bus.restart) begin
            state_next = ST_HOLD;
            retry_next = '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (cnt_reg == CNT_W'(RESET_CYCLES - 1))
                        state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    // timeout outranks a lock arriving on the same cycle
                    if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1))
                        do_retry = 1'b1;
                    else if (lock_s_reg)
                        state_next = ST_STABLE;
                end
                ST_STABLE: begin
                    // a dropout here is treated as a glitch: back to WAIT, no retry spent
                    if (!lock_s_reg)
                        state_next = ST_WAIT;
                    else if (cnt_reg == CNT_W'(STABLE_CYCLES - 1))
                        state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!lock_s_reg)
                        do_retry = 1'b1;
                end
                ST_FAIL: state_next = ST_FAIL;
                default: state_next = ST_HOLD;
            endcase

            if (do_retry) begin
                if (retry_reg == 4'(MAX_RETRIES)) begin
                    state_next = ST_FAIL;
                end else begin
                    retry_next = retry_reg + 4'd1;
                    state_next = ST_HOLD;
                end
            end

            if (state_next == ST_RUN && state_reg != ST_RUN)
                retry_next = '0;
        end

        // counter restarts on every state entry, including a restart that re-enters HOLD
        if (bus.restart || state_next != state_reg)
            cnt_next = '0;
        else if (cnt_reg == {CNT_W{1'b1}})
            cnt_next = cnt_reg;
        else
            cnt_next = cnt_reg + CNT_W'(1);

        pll_resetb_next = !((state_next == ST_HOLD) || (state_next == ST_FAIL && !FALLBACK));
        pll_bypass_next = FALLBACK && (state_next == ST_FAIL);
        sys_rst_n_next  = (state_next == ST_RUN) ||
                          (FALLBACK && state_reg == ST_FAIL && state_next == ST_FAIL &&
                           cnt_reg >= CNT_W'(RESET_CYCLES - 1));
        locked_next     = (state_next == ST_RUN);
        fail_next       = (state_next == ST_FAIL);
    end

    assign bus.pll_resetb = pll_resetb_reg;
    assign bus.pll_bypass = pll_bypass_reg;
    assign bus.sys_rst_n  = sys_rst_n_reg;
    assign bus.locked     = locked_reg;
    assign bus.fail       = fail_reg;
    assign bus.retry_cnt  = retry_reg;
    assign bus.state      = state_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, async reset check, and random lock
// waveforms compared every cycle against a phase/timestamp reference model.
module tb_pll_lock_supervisor;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int MR = 2;

`ifdef PLL_BYPASS_FALLBACK_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    localparam int P_H = 0;
    localparam int P_W = 1;
    localparam int P_S = 2;
    localparam int P_R = 3;
    localparam int P_F = 4;

    logic clk = 1'b0;
    logic resetb = 1'b0;

    pll_lock_supervisor_if bus();

    pll_lock_supervisor #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit lock;
        bit rst;
        int n;
        int st;
        int retry;
        bit sys;
    } vec_t;

    vec_t vecs[$];

    // reference model: current phase, the edge it was entered on, and a 2-deep lock delay line
    int m_phase, m_entry, m_retry, m_now;
    bit m_d0, m_d1;

    function automatic vec_t mk(bit lock, bit rst, int n, int st, int retry, bit sys);
        vec_t v;
        v.lock = lock; v.rst = rst; v.n = n; v.st = st; v.retry = retry; v.sys = sys;
        return v;
    endfunction

    function automatic logic [11:0] pack_exp(int st, int retry, bit sys);
        bit rb, bp, lk, fl;
        rb = !(st == P_H || (st == P_F && !FB));
        bp = FB && (st == P_F);
        lk = (st == P_R);
        fl = (st == P_F);
        return {st[2:0], retry[3:0], rb, bp, sys, lk, fl};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {bus.state, bus.retry_cnt, bus.pll_resetb, bus.pll_bypass,
                bus.sys_rst_n, bus.locked, bus.fail};
    endfunction

    function automatic logic [11:0] model_vec();
        bit sys;
        sys = (m_phase == P_R) || (FB && m_phase == P_F && (m_now - m_entry) >= RC);
        return pack_exp(m_phase, m_retry, sys);
    endfunction

    function automatic void model_reset();
        m_phase = P_H; m_entry = 0; m_now = 0; m_retry = 0; m_d0 = 1'b0; m_d1 = 1'b0;
    endfunction

    function automatic void model_edge(bit lk, bit rs);
        int  in_phase, nxt;
        bit  ls, retry_ev;
        m_now    = m_now + 1;
        ls       = m_d1;
        in_phase = m_now - m_entry;
        nxt      = m_phase;
        retry_ev = 1'b0;
        if (rs) begin
            nxt     = P_H;
            m_retry = 0;
        end else begin
            if (m_phase == P_H && in_phase == RC) nxt = P_W;
            if (m_phase == P_W) begin
                if (in_phase == LT) retry_ev = 1'b1;
                else if (ls)        nxt = P_S;
            end
            if (m_phase == P_S) begin
                if (!ls)                 nxt = P_W;
                else if (in_phase == SC) nxt = P_R;
            end
            if (m_phase == P_R && !ls) retry_ev = 1'b1;
            if (retry_ev) begin
                if (m_retry == MR) nxt = P_F;
                else begin
                    m_retry = m_retry + 1;
                    nxt     = P_H;
                end
            end
            if (nxt == P_R && m_phase != P_R) m_retry = 0;
        end
        if (rs || nxt != m_phase) m_entry = m_now;
        m_phase = nxt;
        m_d1 = m_d0;
        m_d0 = lk;
    endfunction

    task automatic check(string name, logic [11:0] got, logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got state=%0d retry=%0d rb/bp/sys/lk/fl=%b, want state=%0d retry=%0d rb/bp/sys/lk/fl=%b",
                     name, $time, got[11:9], got[8:5], got[4:0], want[11:9], want[8:5], want[4:0]);
        end
    endtask

    // called at a negedge: drive, let one posedge happen, compare at the next negedge
    task automatic tick(bit lk, bit rs, string name);
        bus.pll_lock = lk;
        bus.restart  = rs;
        @(posedge clk);
        model_edge(lk, rs);
        @(negedge clk);
        check(name, dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        bus.pll_lock = 1'b0;
        bus.restart  = 1'b0;
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_values", dut_vec(), 12'h000);
        resetb = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.pll_lock = 1'b0;
        bus.restart  = 1'b0;
        @(negedge clk);
        do_reset();

        // clean lock: pll_resetb low 4 cycles, lock 10 cycles after release, RUN 11 edges later
        vecs.push_back(mk(0, 0, 3,  P_H, 0, 0));
        vecs.push_back(mk(0, 0, 1,  P_W, 0, 0));
        vecs.push_back(mk(0, 0, 10, P_W, 0, 0));
        vecs.push_back(mk(1, 0, 10, P_S, 0, 0));
        vecs.push_back(mk(1, 0, 1,  P_R, 0, 1));
        // glitch during STABLE
        vecs.push_back(mk(0, 1, 1,  P_H, 0, 0));
        vecs.push_back(mk(0, 0, 4,  P_W, 0, 0));
        vecs.push_back(mk(1, 0, 3,  P_S, 0, 0));
        vecs.push_back(mk(0, 0, 1,  P_S, 0, 0));
        vecs.push_back(mk(1, 0, 1,  P_S, 0, 0));
        vecs.push_back(mk(1, 0, 1,  P_W, 0, 0));
        vecs.push_back(mk(1, 0, 8,  P_S, 0, 0));
        vecs.push_back(mk(1, 0, 1,  P_R, 0, 1));
        // lock loss in RUN
        vecs.push_back(mk(0, 0, 2,  P_R, 0, 1));
        vecs.push_back(mk(0, 0, 1,  P_H, 1, 0));
        vecs.push_back(mk(0, 0, 3,  P_H, 1, 0));
        vecs.push_back(mk(0, 0, 1,  P_W, 1, 0));
        // never lock: three timeouts then FAIL
        vecs.push_back(mk(0, 1, 1,  P_H, 0, 0));
        vecs.push_back(mk(0, 0, 4,  P_W, 0, 0));
        vecs.push_back(mk(0, 0, 32, P_H, 1, 0));
        vecs.push_back(mk(0, 0, 4,  P_W, 1, 0));
        vecs.push_back(mk(0, 0, 32, P_H, 2, 0));
        vecs.push_back(mk(0, 0, 4,  P_W, 2, 0));
        vecs.push_back(mk(0, 0, 31, P_W, 2, 0));
        vecs.push_back(mk(0, 0, 1,  P_F, 2, 0));
        vecs.push_back(mk(0, 0, 3,  P_F, 2, 0));
        vecs.push_back(mk(0, 0, 1,  P_F, 2, FB));
        // restart in FAIL on the cycle lock falls, then walk into STABLE
        vecs.push_back(mk(1, 0, 3,  P_F, 2, FB));
        vecs.push_back(mk(0, 1, 1,  P_H, 0, 0));
        vecs.push_back(mk(0, 0, 4,  P_W, 0, 0));
        vecs.push_back(mk(1, 0, 3,  P_S, 0, 0));
        vecs.push_back(mk(1, 0, 3,  P_S, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                tick(vecs[i].lock, (k == 0) ? vecs[i].rst : 1'b0, $sformatf("model_v%0d", i));
            end
            check($sformatf("vec%0d", i), dut_vec(),
                  pack_exp(vecs[i].st, vecs[i].retry, vecs[i].sys));
            $display("vec %0d lock=%0b restart=%0b cycles=%0d state=%0d retry=%0d sys_rst_n=%0b",
                     i, vecs[i].lock, vecs[i].rst, vecs[i].n, bus.state, bus.retry_cnt, bus.sys_rst_n);
        end

        // asynchronous reset mid-STABLE, checked between clock edges
        #2 resetb = 1'b0;
        #1 check("async_reset", dut_vec(), 12'h000);
        $display("async reset at %0t state=%0d", $time, bus.state);
        @(negedge clk);
        do_reset();

        for (int seg = 0; seg < 120; seg++) begin
            bit lk;
            int len;
            lk  = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                tick(lk, ($urandom_range(0, 199) == 0), "random");
            end
            $display("seg %0d lock=%0b len=%0d state=%0d retry=%0d", seg, lk, len, bus.state, bus.retry_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
